counter_cmd_ctrl: RTL and testbench
===================================

Name: counter_cmd_ctrl

Overview:
Operator-command front end for the up/down counter FSM. It synchronises and debounces four raw push-buttons (run, step, direction, clear) and runs a small control FSM. The FSM drives the counter's act and up_dwn_n inputs, watches its ovflw output, and generates the counter's active-low clear. It sits directly upstream of the counter and consumes the counter's overflow flag.

Parameters:
DB_WIDTH, 16, width of each per-button debounce counter
DB_LIMIT, 50000, consecutive stable synchronised cycles needed to accept a button level change (2 <= DB_LIMIT <= 2^DB_WIDTH-1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
btn_run  input  1  raw, asynchronous, bouncy; toggles free-run
btn_step  input  1  raw; requests a single count
btn_dir  input  1  raw; toggles count direction
btn_clr  input  1  raw; clears counter and leaves HALT
ovflw  input  1  overflow flag from counter
act  output  1  counter enable
up_dwn_n  output  1  1 = count up, 0 = count down
cnt_rst_n  output  1  active-low clear to counter
halted  output  1  high while in HALT

Behaviour:
- Input path, per button: 2-flop synchroniser, then debouncer.
  - Debouncer holds a stable level b (reset 0) and a counter cnt (reset 0).
  - If sync != b: cnt increments. When sync != b with cnt == DB_LIMIT-1: b <= sync and cnt <= 0.
  - If sync == b: cnt <= 0. Any glitch restarts the count.
- Press pulse: 1-cycle registered pulse, high in the first cycle b reads 1. Release generates no pulse.
- Latency: a clean raw rise produces the pulse DB_LIMIT+2 or DB_LIMIT+3 cycles later, depending on sampling phase.
- FSM, one-hot: IDLE, RUN, STEP, HALT. Reset state is IDLE.
- Transition priority, highest first:
  1. ovflw==1 and cnt_rst_n==1 in IDLE/RUN/STEP -> HALT.
  2. HALT: clr press -> IDLE; all other presses ignored.
  3. IDLE: run press -> RUN, else step press -> STEP.
  4. RUN: run press -> IDLE. Step press ignored.
  5. STEP -> IDLE unconditionally after one cycle. Presses arriving during STEP are ignored, except dir.
- Outputs and registers:
  - act = 1 exactly when state is RUN or STEP, so STEP gives exactly one act cycle.
  - dir register drives up_dwn_n. Reset 1. A dir press toggles it in IDLE, RUN or STEP; ignored in HALT. The toggle takes effect the cycle after the pulse.
  - halted = 1 exactly when state is HALT.
  - cnt_rst_n is registered:
    - 0 on the cycle after rst is sampled high, held 0 while rst is high, 1 on the cycle after rst is released.
    - Goes 0 for exactly one cycle on the same edge that HALT -> IDLE.
    - ovflw is ignored while cnt_rst_n==0, covering the counter's async clear settling.
- Simultaneous presses:
  - run and step in IDLE -> RUN.
  - dir with any other press: both take effect.
  - clr outside HALT is ignored and does not pulse cnt_rst_n.
- Reset mid-operation: rst in any state returns, on the next edge, to IDLE, dir=1, act=0, cnt_rst_n=0. Debouncer b/cnt and synchroniser flops clear to 0. A button held through reset re-qualifies and produces one press after release of rst + DB_LIMIT cycles.
- Reset values: act=0, up_dwn_n=1, cnt_rst_n=0, halted=0.

Test Plan:
- Reset and debounce (DB_LIMIT=4, model counter attached): hold rst 3 cycles, release -> act=0, up_dwn_n=1, halted=0, cnt_rst_n=0 then 1. Bounce btn_run 1,0,1,0 on consecutive cycles, then hold 1 -> exactly one press after 4 stable cycles; state RUN, act=1 continuous.
- Step: from IDLE, clean btn_step press -> act high exactly 1 cycle, counter count 0->1. Second step press -> count 2.
- Direction: in RUN with count=5, press btn_dir -> up_dwn_n 1->0 next cycle, count decreases 5,4,3. A dir press in HALT leaves up_dwn_n unchanged.
- Overflow/clear: run up from 0 until the counter overflows -> ovflw=1 makes the next state HALT, act=0, halted=1. Run and step presses are ignored. Clr press -> cnt_rst_n low exactly 1 cycle, count=0, ovflw=0, state IDLE, no re-entry to HALT.
- Simultaneous: run and step pulses in the same IDLE cycle -> RUN, act held high. Clr press in RUN -> no cnt_rst_n pulse, remains RUN.
- Reset mid-run: assert rst while in RUN with dir=0 -> next edge act=0, up_dwn_n=1, cnt_rst_n=0, state IDLE. btn_run held through reset -> exactly one press DB_LIMIT(+sync) cycles after rst release.

Source files
------------

// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - operator push-button front end and control FSM for the up/down counter
module counter_cmd_ctrl #(
    parameter int DB_WIDTH = 16,
    parameter int DB_LIMIT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    input  logic btn_dir,
    input  logic btn_clr,
    input  logic ovflw,
    output logic act,
    output logic up_dwn_n,
    output logic cnt_rst_n,
    output logic halted
);

    localparam int NB      = 4;
    localparam int B_RUN   = 0;
    localparam int B_STEP  = 1;
    localparam int B_DIR   = 2;
    localparam int B_CLR   = 3;
    localparam logic [DB_WIDTH-1:0] LP_LIMIT_M1 = DB_WIDTH'(DB_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_RUN  = 4'b0010,
        S_STEP = 4'b0100,
        S_HALT = 4'b1000
    } state_t;

    logic [NB-1:0]       w_btn_raw;
    logic [NB-1:0]       r_sync1;
    logic [NB-1:0]       r_sync2;
    logic [NB-1:0]       r_db_b;
    logic [DB_WIDTH-1:0] r_db_cnt [NB];
    logic [NB-1:0]       r_press;

    state_t r_state;
    state_t w_next;
    logic   r_dir;
    logic   r_cnt_rst_n;
    logic   w_clr_go;

    assign w_btn_raw = {btn_clr, btn_dir, btn_step, btn_run};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The press pulse is registered alongside the level so it lines up with the first cycle b reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_b  <= '0;
            r_press <= '0;
            for (int i = 0; i < NB; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] != r_db_b[i]) begin
                    if (r_db_cnt[i] == LP_LIMIT_M1) begin
                        r_db_b[i]   <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                        r_press[i]  <= r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_WIDTH'(1);
                        r_press[i]  <= 1'b0;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                    r_press[i]  <= 1'b0;
                end
            end
        end
    end

    // Overflow is masked while the counter is still being cleared.
    always_comb begin
        w_next = r_state;
        if (r_state != S_HALT && ovflw && r_cnt_rst_n) begin
            w_next = S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_press[B_RUN]) begin
                        w_next = S_RUN;
                    end else if (r_press[B_STEP]) begin
                        w_next = S_STEP;
                    end
                end
                S_RUN: begin
                    if (r_press[B_RUN]) begin
                        w_next = S_IDLE;
                    end
                end
                S_STEP: w_next = S_IDLE;
                S_HALT: begin
                    if (r_press[B_CLR]) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_clr_go = (r_state == S_HALT) && r_press[B_CLR];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b1;
            r_cnt_rst_n <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt_rst_n <= ~w_clr_go;
            if (r_press[B_DIR] && r_state != S_HALT) begin
                r_dir <= ~r_dir;
            end
        end
    end

    assign act       = (r_state == S_RUN) || (r_state == S_STEP);
    assign halted    = (r_state == S_HALT);
    assign up_dwn_n  = r_dir;
    assign cnt_rst_n = r_cnt_rst_n;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - directed bench for counter_cmd_ctrl with a 4-bit counter model attached
module tb_counter_cmd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic btn_dir = 1'b0;
    logic btn_clr = 1'b0;
    logic ovflw;
    logic act;
    logic up_dwn_n;
    logic cnt_rst_n;
    logic halted;

    logic [3:0] m_cnt = 4'd0;
    logic       m_ovf = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    counter_cmd_ctrl #(
        .DB_WIDTH(4),
        .DB_LIMIT(4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_dir  (btn_dir),
        .btn_clr  (btn_clr),
        .ovflw    (ovflw),
        .act      (act),
        .up_dwn_n (up_dwn_n),
        .cnt_rst_n(cnt_rst_n),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Counter model: async active-low clear, sticky overflow on the up-wrap only.
    always @(posedge clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n) begin
            m_cnt <= 4'd0;
            m_ovf <= 1'b0;
        end else if (act) begin
            if (up_dwn_n) begin
                if (m_cnt == 4'd15) begin
                    m_cnt <= 4'd0;
                    m_ovf <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 4'd1;
                end
            end else begin
                m_cnt <= m_cnt - 4'd1;
            end
        end
    end
    assign ovflw = m_ovf;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        tick(3);
        check("rst_act", act, 0);
        check("rst_up", up_dwn_n, 1);
        check("rst_halted", halted, 0);
        check("rst_cnt_rst_n", cnt_rst_n, 0);
        rst = 1'b0;
        tick(1);
        check("rel_cnt_rst_n", cnt_rst_n, 1);
        check("rel_cnt", m_cnt, 0);

        // bounce run, then hold
        btn_run = 1'b1; tick(1);
        btn_run = 1'b0; tick(1);
        btn_run = 1'b1; tick(1);
        btn_run = 1'b0; tick(1);
        btn_run = 1'b1;
        tick(5);
        btn_dir = 1'b1;
        tick(1);
        check("run_not_early", act, 0);
        tick(1);
        check("run_act", act, 1);
        check("run_cnt0", m_cnt, 0);
        check("run_up", up_dwn_n, 1);
        btn_run = 1'b0;
        tick(4);
        check("run_cnt4", m_cnt, 4);
        check("dir_still_up", up_dwn_n, 1);
        tick(1);
        check("run_cnt5", m_cnt, 5);
        check("dir_down", up_dwn_n, 0);
        tick(1);
        check("down_cnt4", m_cnt, 4);
        tick(1);
        check("down_cnt3", m_cnt, 3);
        check("run_act_held", act, 1);
        btn_dir = 1'b0;
        btn_run = 1'b1;
        tick(6);
        check("stop_pending_act", act, 1);
        tick(1);
        check("stop_act", act, 0);
        check("stop_cnt", m_cnt, 12);
        btn_run = 1'b0;

        // step with simultaneous dir, then a plain step
        tick(7);
        btn_step = 1'b1;
        btn_dir  = 1'b1;
        tick(7);
        check("step_act", act, 1);
        check("step_dir_up", up_dwn_n, 1);
        check("step_cnt_before", m_cnt, 12);
        tick(1);
        check("step_act_one", act, 0);
        check("step_cnt13", m_cnt, 13);
        btn_step = 1'b0;
        btn_dir  = 1'b0;
        tick(7);
        btn_step = 1'b1;
        tick(7);
        check("step2_act", act, 1);
        tick(1);
        check("step2_act_one", act, 0);
        check("step2_cnt14", m_cnt, 14);
        btn_step = 1'b0;

        // run+step together, clr while running, then overflow
        tick(7);
        btn_run  = 1'b1;
        btn_step = 1'b1;
        tick(2);
        btn_clr = 1'b1;
        tick(5);
        check("sim_act", act, 1);
        check("sim_cnt14", m_cnt, 14);
        check("sim_not_halted", halted, 0);
        tick(1);
        check("sim_cnt15", m_cnt, 15);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_clr  = 1'b0;
        tick(1);
        check("ovf_flag", m_ovf, 1);
        check("clr_in_run_no_pulse", cnt_rst_n, 1);
        check("ovf_still_run", act, 1);
        check("ovf_pre_halt", halted, 0);
        tick(1);
        check("halt_halted", halted, 1);
        check("halt_act", act, 0);
        check("halt_cnt", m_cnt, 1);

        // presses ignored in HALT
        tick(5);
        btn_run  = 1'b1;
        btn_step = 1'b1;
        btn_dir  = 1'b1;
        tick(7);
        check("halt_ign_halted", halted, 1);
        check("halt_ign_act", act, 0);
        check("halt_ign_dir", up_dwn_n, 1);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_dir  = 1'b0;

        // clear out of HALT
        tick(7);
        btn_clr = 1'b1;
        tick(6);
        check("clr_pre_halted", halted, 1);
        check("clr_pre_rst_n", cnt_rst_n, 1);
        tick(1);
        check("clr_halted", halted, 0);
        check("clr_rst_n_low", cnt_rst_n, 0);
        check("clr_cnt", m_cnt, 0);
        check("clr_ovf", m_ovf, 0);
        check("clr_act", act, 0);
        btn_clr = 1'b0;
        tick(1);
        check("clr_rst_n_one", cnt_rst_n, 1);
        check("clr_idle", halted, 0);
        tick(2);
        check("clr_no_rehalt", halted, 0);

        // reset mid-run with dir=0 and run held through reset
        tick(4);
        btn_run = 1'b1;
        btn_dir = 1'b1;
        tick(7);
        check("mid_act", act, 1);
        check("mid_dir", up_dwn_n, 0);
        btn_dir = 1'b0;
        tick(2);
        check("mid_act_held", act, 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_act", act, 0);
        check("mid_rst_up", up_dwn_n, 1);
        check("mid_rst_cnt_rst_n", cnt_rst_n, 0);
        check("mid_rst_halted", halted, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("mid_rel_cnt_rst_n", cnt_rst_n, 1);
        check("mid_rel_act", act, 0);
        tick(5);
        check("requal_not_early", act, 0);
        tick(1);
        check("requal_act", act, 1);
        tick(10);
        check("requal_single", act, 1);
        btn_run = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
